jt89_ctrl: RTL and testbench

Register front end for the JT89 PSG: decodes the SN76489 latch/data byte protocol from a CPU write port into the three 10-bit tone periods, four 4-bit attenuations and the noise control. It also divides the chip clock enable by 16 to produce the enable strobe that drives the tone counters. It sits between the host bus and the three tone channels plus the noise channel, and is the only writer of their configuration.

---
 rtl/jt89_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_jt89_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jt89_ctrl.sv
// jt89_ctrl - register front end for the JT89 PSG.
//
// Decodes the SN76489 latch/data byte protocol from a CPU write port into the
// three 10-bit tone periods, four 4-bit attenuations and the 3-bit noise
// control. It also divides the chip clock enable by 16 to produce the strobe
// that drives the tone counters.
//
// Optional feature: define JT89_READY_EN to enable the write-busy window.
// While enabled, each accepted write holds ready low for 32 cen pulses.
// Write edges that arrive during that window are consumed and dropped. With
// the macro undefined, ready is tied high and every write edge is applied.
//
// Write port handshake: a write is one falling level of wr_n seen on clk
// (wr_n low now, high in the previous cycle). With JT89_READY_EN, a write is
// taken only when ready is high in that same cycle. Otherwise it is discarded.
// The host never needs to retry; holding wr_n low never repeats a write.

module jt89_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic [7:0] din,
  input  logic       wr_n,
  output logic [9:0] tone0,
  output logic [9:0] tone1,
  output logic [9:0] tone2,
  output logic [3:0] vol0,
  output logic [3:0] vol1,
  output logic [3:0] vol2,
  output logic [3:0] vol3,
  output logic [2:0] noise_ctrl,
  output logic       noise_rst,
  output logic       clken_tone,
  output logic       ready
);

  // ---------------------------------------------------------------------------
  // Write edge detection
  // ---------------------------------------------------------------------------
  logic wr_n_q;
  logic wr_edge;
  logic wr_accept;

  // Previous wr_n level; resets high so a strobe held low across reset
  // still produces one write right after release.
  always_ff @(posedge clk) begin
    if (rst) wr_n_q <= 1'b1;
    else     wr_n_q <= wr_n;
  end

  assign wr_edge = ~wr_n & wr_n_q;

`ifdef JT89_READY_EN
  // ---------------------------------------------------------------------------
  // Busy window: 32 cen pulses after every accepted write
  // ---------------------------------------------------------------------------
  logic [5:0] busy_cnt;

  assign wr_accept = wr_edge & ready;

  // Load the busy counter on an accepted write, count cen pulses down,
  // and raise ready again in the cycle after the 32nd pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_cnt <= 6'd0;
      ready    <= 1'b1;
    end else if (wr_accept) begin
      busy_cnt <= 6'd32;
      ready    <= 1'b0;
    end else if (!ready && cen) begin
      if (busy_cnt == 6'd1) ready <= 1'b1;
      busy_cnt <= busy_cnt - 6'd1;
    end
  end
`else
  assign wr_accept = wr_edge;
  assign ready     = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Latch register: channel and type targeted by following data bytes
  // ---------------------------------------------------------------------------
  logic [1:0] latch_ch;
  logic       latch_vol;

  // A latch byte (din[7]=1) records channel/type on the same edge that its
  // low nibble is applied; data bytes leave it untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      latch_ch  <= 2'd0;
      latch_vol <= 1'b0;
    end else if (wr_accept && din[7]) begin
      latch_ch  <= din[6:5];
      latch_vol <= din[4];
    end
  end

  // ---------------------------------------------------------------------------
  // Target decode
  // ---------------------------------------------------------------------------
  logic       is_latch;
  logic [1:0] sel_ch;
  logic       sel_vol;
  logic [2:0] tone_we;
  logic [3:0] vol_we;
  logic       noise_we;

  assign is_latch = din[7];
  assign sel_ch   = is_latch ? din[6:5] : latch_ch;
  assign sel_vol  = is_latch ? din[4]   : latch_vol;

  // One-hot write enables for each destination register; the latch byte
  // takes its target from din itself, the data byte from the latch.
  always_comb begin
    tone_we  = 3'b000;
    vol_we   = 4'b0000;
    noise_we = 1'b0;
    if (wr_accept) begin
      if (sel_vol) begin
        vol_we[sel_ch] = 1'b1;
      end else if (sel_ch == 2'd3) begin
        noise_we = 1'b1;
      end else begin
        tone_we[sel_ch] = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tone period registers
  // ---------------------------------------------------------------------------
  // A latch byte writes bits [3:0]; a data byte writes bits [9:4]. The other
  // half of the period keeps its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      tone0 <= 10'd0;
      tone1 <= 10'd0;
      tone2 <= 10'd0;
    end else begin
      if (tone_we[0]) begin
        if (is_latch) tone0[3:0] <= din[3:0];
        else          tone0[9:4] <= din[5:0];
      end
      if (tone_we[1]) begin
        if (is_latch) tone1[3:0] <= din[3:0];
        else          tone1[9:4] <= din[5:0];
      end
      if (tone_we[2]) begin
        if (is_latch) tone2[3:0] <= din[3:0];
        else          tone2[9:4] <= din[5:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Attenuation registers
  // ---------------------------------------------------------------------------
  // Latch and data bytes both carry a full 4-bit attenuation in din[3:0].
  always_ff @(posedge clk) begin
    if (rst) begin
      vol0 <= 4'hF;
      vol1 <= 4'hF;
      vol2 <= 4'hF;
      vol3 <= 4'hF;
    end else begin
      if (vol_we[0]) vol0 <= din[3:0];
      if (vol_we[1]) vol1 <= din[3:0];
      if (vol_we[2]) vol2 <= din[3:0];
      if (vol_we[3]) vol3 <= din[3:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Noise control
  // ---------------------------------------------------------------------------
  // Any noise write updates the mode/rate and restarts the noise LFSR with
  // a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      noise_ctrl <= 3'd0;
      noise_rst  <= 1'b0;
    end else begin
      noise_rst <= noise_we;
      if (noise_we) noise_ctrl <= din[2:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Tone clock divider
  // ---------------------------------------------------------------------------
  logic [3:0] div_cnt;

  // Count cen pulses modulo 16; strobe once on the pulse that wraps 15->0.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt    <= 4'd0;
      clken_tone <= 1'b0;
    end else begin
      clken_tone <= cen && (div_cnt == 4'd15);
      if (cen) div_cnt <= div_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_jt89_ctrl.sv
// tb_jt89_ctrl - self-checking bench for jt89_ctrl.
// The reference model holds the PSG register file as plain arrays.
// It applies each accepted byte by the latch/data protocol rules.
// Expected snapshots are queued with the cycle they must appear in, and a
// monitor on the falling edge pops and compares them against the DUT.

module tb_jt89_ctrl;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cen = 1'b1;
  logic [7:0] din = 8'd0;
  logic       wr_n = 1'b1;

  logic [9:0] tone0, tone1, tone2;
  logic [3:0] vol0, vol1, vol2, vol3;
  logic [2:0] noise_ctrl;
  logic       noise_rst;
  logic       clken_tone;
  logic       ready;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  jt89_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .din        (din),
    .wr_n       (wr_n),
    .tone0      (tone0),
    .tone1      (tone1),
    .tone2      (tone2),
    .vol0       (vol0),
    .vol1       (vol1),
    .vol2       (vol2),
    .vol3       (vol3),
    .noise_ctrl (noise_ctrl),
    .noise_rst  (noise_rst),
    .clken_tone (clken_tone),
    .ready      (ready)
  );

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  logic [9:0] m_tone [3];
  logic [3:0] m_vol  [4];
  logic [2:0] m_noise;
  logic [1:0] m_ch;
  logic       m_isvol;

  function automatic void model_reset();
    for (int i = 0; i < 3; i++) m_tone[i] = 10'd0;
    for (int i = 0; i < 4; i++) m_vol[i] = 4'hF;
    m_noise = 3'd0;
    m_ch    = 2'd0;
    m_isvol = 1'b0;
  endfunction

  function automatic logic [49:0] snap(input logic nr);
    return {m_tone[0], m_tone[1], m_tone[2], m_vol[0], m_vol[1], m_vol[2],
            m_vol[3], m_noise, nr};
  endfunction

  // Apply one accepted byte and return the register snapshot it produces.
  function automatic logic [49:0] model_apply(input logic [7:0] d);
    logic nr;
    int   lo;
    nr = 1'b0;
    if (d[7]) begin
      m_ch    = d[6:5];
      m_isvol = d[4];
    end
    if (m_isvol) begin
      m_vol[m_ch] = d[3:0];
    end else if (m_ch == 2'd3) begin
      m_noise = d[2:0];
      nr      = 1'b1;
    end else if (d[7]) begin
      lo = int'(m_tone[m_ch]) / 16;
      m_tone[m_ch] = 10'(lo * 16 + int'(d[3:0]));
    end else begin
      lo = int'(m_tone[m_ch]) % 16;
      m_tone[m_ch] = 10'(int'(d[5:0]) * 16 + lo);
    end
    return snap(nr);
  endfunction

  // ---------------------------------------------------------------------------
  // Divider and busy-window model (cen pulse counting)
  // ---------------------------------------------------------------------------
  int   cen_cnt   = 0;
  int   busy_left = 0;
  logic exp_clken = 1'b0;
  int   cen_mode  = 0;

  always @(posedge clk) begin
    if (rst) begin
      cen_cnt   = 0;
      exp_clken = 1'b0;
      busy_left = 0;
    end else begin
      exp_clken = cen && (cen_cnt % 16 == 15);
      if (cen) begin
        cen_cnt = cen_cnt + 1;
        if (busy_left > 0) busy_left = busy_left - 1;
      end
    end
  end

  // cen pattern: 0 = always on, 1 = random, 2 = every second cycle
  always @(posedge clk) begin
    #1;
    case (cen_mode)
      0:       cen = 1'b1;
      1:       cen = 1'($urandom_range(0, 1));
      default: cen = ~cen;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor
  // ---------------------------------------------------------------------------
  logic [49:0] exp_q [$];
  int          due_q [$];
  logic [49:0] cur_exp = '0;
  logic [49:0] dut_v;
  logic        mon_on = 1'b0;
  int          checks = 0;
  int          failures = 0;

  always @(negedge clk) begin
    if (mon_on) begin
      cur_exp[0] = 1'b0;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        checks++;
        failures++;
        $display("FAIL stale_expect due=%0d now=%0d", due_q[0], cyc);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        cur_exp = exp_q.pop_front();
        void'(due_q.pop_front());
      end
      dut_v = {tone0, tone1, tone2, vol0, vol1, vol2, vol3, noise_ctrl, noise_rst};
      checks++;
      if (dut_v !== cur_exp) begin
        failures++;
        $display("FAIL regs cyc=%0d got t=%h/%h/%h v=%h%h%h%h n=%h nr=%b exp t=%h/%h/%h v=%h%h%h%h n=%h nr=%b",
                 cyc, tone0, tone1, tone2, vol0, vol1, vol2, vol3, noise_ctrl, noise_rst,
                 cur_exp[49:40], cur_exp[39:30], cur_exp[29:20], cur_exp[19:16],
                 cur_exp[15:12], cur_exp[11:8], cur_exp[7:4], cur_exp[3:1], cur_exp[0]);
      end
      checks++;
      if (clken_tone !== exp_clken) begin
        failures++;
        $display("FAIL clken_tone cyc=%0d got=%b exp=%b", cyc, clken_tone, exp_clken);
      end
      checks++;
      if (ready !== (busy_left == 0)) begin
        failures++;
        $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, ready, busy_left == 0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Drive one write strobe; wr_n stays low for 'hold' cycles with din
  // scrambled after the first, which must not cause a second write.
  task automatic write_byte(input logic [7:0] d, input int hold);
    logic acc;
    @(posedge clk); #1;
    din  = d;
    wr_n = 1'b0;
    acc  = (busy_left == 0);
    if (acc) begin
      exp_q.push_back(model_apply(d));
      due_q.push_back(cyc + 1);
    end
    @(posedge clk); #1;
`ifdef JT89_READY_EN
    if (acc) busy_left = 32;
`endif
    din = 8'($urandom);
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
    end
    wr_n = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    exp_q.push_back(snap(1'b0));
    due_q.push_back(cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reset while a latch is pending, with wr_n going low in the reset cycle
  // and held through release: the write lands once, after release.
  task automatic reset_with_held_write(input logic [7:0] d);
    @(posedge clk); #1;
    rst  = 1'b1;
    din  = d;
    wr_n = 1'b0;
    model_reset();
    exp_q.push_back(snap(1'b0));
    due_q.push_back(cyc + 1);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.push_back(model_apply(d));
    due_q.push_back(cyc + 1);
    @(posedge clk); #1;
`ifdef JT89_READY_EN
    busy_left = 32;
`endif
    @(posedge clk); #1;
    wr_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    cur_exp = snap(1'b0);
    mon_on  = 1'b1;

    // Reset values and free-running divider with cen always on
    repeat (40) @(posedge clk);

    // Tone ch0 from a latch + data pair
    write_byte(8'h8E, 1);
    write_byte(8'h0F, 1);
    // Volume ch2, then a data byte re-targeting the latched volume
    write_byte(8'hD5, 1);
    write_byte(8'h07, 2);
    // Noise via latch and data byte, each pulsing noise_rst
    write_byte(8'hE6, 1);
    write_byte(8'h03, 1);
    // Long hold: exactly one write
    write_byte(8'h85, 4);
    // Latch ch1 tone, then reset mid-sequence; data lands in tone0[9:4]
    write_byte(8'hA4, 1);
    reset_with_held_write(8'h3F);
    repeat (4) @(posedge clk);

    // cen every 2nd cycle; second write falls inside the busy window when enabled
    do_reset();
    cen_mode = 2;
    write_byte(8'h9A, 1);
    repeat (8) @(posedge clk);
    write_byte(8'h92, 1);
    repeat (80) @(posedge clk);

    // Randomized traffic with random cen and occasional resets
    cen_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) cen_mode = 0;
      if ($urandom_range(0, 40) == 0) do_reset();
      write_byte(8'($urandom), $urandom_range(1, 3));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (due_q.size() != 0) begin
      failures++;
      $display("FAIL pending_expect got=%0d exp=0", due_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: the stimulus is fixed-length, but never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
